// File: rtl/ifq_fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory request/response, redirect, and decode handshake.
// The master modport is the fetch unit; the slave modport is memory, branch logic and decode together.
interface ifq_fetch_unit_if #(
  parameter int XLEN = 64
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            id_ready;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [XLEN-1:0] id_pc;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata,
    input  redirect,
    input  redirect_pc,
    input  id_ready,
    output id_valid,
    output id_instr,
    output id_pc
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata,
    output redirect,
    output redirect_pc,
    output id_ready,
    input  id_valid,
    input  id_instr,
    input  id_pc
  );
endinterface

// File: rtl/ifq_fetch_unit.sv
// Sequential instruction fetch with a DEPTH-entry prefetch queue feeding the IF/ID register.
// Define IFQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module ifq_fetch_unit #(
  parameter int              DEPTH    = 4,
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  ifq_fetch_unit_if.master  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [31:0]     q_instr [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            inflight;
  logic            stale;

  logic            issue;
  logic            push_ok;
  logic            q_valid;
  logic            store;
  logic            pop;

  // Credit is taken from the registered count, so a same-cycle pop cannot fund a new request.
  assign issue   = !reset && !bus.redirect && ((count + CW'(inflight)) < CW'(DEPTH));
  assign push_ok = !reset && !bus.redirect && bus.imem_rvalid && inflight && !stale;
  assign q_valid = !reset && (count != '0);

  assign bus.imem_req  = issue;
  assign bus.imem_addr = reset ? RESET_PC : fetch_pc;

`ifdef IFQ_BYPASS_EN
  logic bypass;

  assign bypass = push_ok && (count == '0);

  always_comb begin
    bus.id_valid = q_valid || bypass;
    bus.id_instr = '0;
    bus.id_pc    = '0;
    if (q_valid) begin
      bus.id_instr = q_instr[rd_ptr];
      bus.id_pc    = q_pc[rd_ptr];
    end else if (bypass) begin
      bus.id_instr = bus.imem_rdata;
      bus.id_pc    = inflight_pc;
    end
  end

  // A bypassed word that decode takes immediately never occupies a slot.
  assign store = push_ok && !(bypass && bus.id_ready);
`else
  always_comb begin
    bus.id_valid = q_valid;
    bus.id_instr = '0;
    bus.id_pc    = '0;
    if (q_valid) begin
      bus.id_instr = q_instr[rd_ptr];
      bus.id_pc    = q_pc[rd_ptr];
    end
  end

  assign store = push_ok;
`endif

  assign pop = q_valid && bus.id_ready && !bus.redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      inflight_pc <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      inflight    <= 1'b0;
      stale       <= 1'b0;
    end else if (bus.redirect) begin
      fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      inflight <= 1'b0;
      stale    <= inflight;
    end else begin
      if (issue) begin
        fetch_pc    <= fetch_pc + XLEN'(4);
        inflight    <= 1'b1;
        inflight_pc <= fetch_pc;
        stale       <= 1'b0;
      end else begin
        inflight <= 1'b0;
      end
      if (store) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (store && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !store) begin
        count <= count - CW'(1);
      end
    end
  end

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (store) begin
      q_pc[wr_ptr]    <= inflight_pc;
      q_instr[wr_ptr] <= bus.imem_rdata;
    end
  end
endmodule

// File: tb/tb_ifq_fetch_unit.sv
// Self-checking bench for ifq_fetch_unit: behavioural memory, expected-PC scoreboard, scenario tasks.
// Build with IFQ_BYPASS_EN defined to check the bypass latency variant.
module tb_ifq_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam int          XLEN     = 64;
  localparam logic [63:0] RESET_PC = 64'h0;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ifq_fetch_unit_if #(.XLEN(XLEN)) bus ();

  ifq_fetch_unit #(.DEPTH(DEPTH), .XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   req_cnt     = 0;
  int   acc_cnt     = 0;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // Memory: answers every request exactly one cycle later.
  logic        req_s  = 1'b0;
  logic [63:0] addr_s = '0;
  always @(negedge clk) begin
    req_s  = bus.imem_req;
    addr_s = bus.imem_addr;
    if (bus.imem_req === 1'b1) req_cnt++;
  end
  always @(posedge clk) begin
    #1;
    bus.imem_rvalid = req_s;
    bus.imem_rdata  = req_s ? mem_word(addr_s) : 32'hdead_beef;
  end

  // Scoreboard: every accepted decode handshake must match the next expected entry.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.redirect === 1'b0 && bus.id_ready === 1'b1 && bus.id_valid === 1'b1) begin
      exp_t e;
      acc_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL deliver_unexpected got pc=%0h instr=%0h want none", bus.id_pc, bus.id_instr);
      end else begin
        e = exp_q.pop_front();
        if (bus.id_pc !== e.pc || bus.id_instr !== e.instr) begin
          miscompares++;
          $display("FAIL deliver got pc=%0h instr=%0h want pc=%0h instr=%0h",
                   bus.id_pc, bus.id_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stream(input logic [63:0] start);
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      logic [63:0] p;
      p = start + 64'(4 * i);
      exp_q.push_back('{pc: p, instr: mem_word(p)});
    end
  endtask

  task automatic release_reset();
    tick();
    reset = 1'b0;
    expect_stream(RESET_PC);
    req_cnt = 0;
    acc_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    vectors += 5;
    if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req got %0b want 0", bus.imem_req); end
    if (bus.imem_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_addr got %0h want %0h", bus.imem_addr, RESET_PC); end
    if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b want 0", bus.id_valid); end
    if (bus.id_instr !== 32'h0) begin miscompares++; $display("FAIL reset_instr got %0h want 0", bus.id_instr); end
    if (bus.id_pc !== 64'h0) begin miscompares++; $display("FAIL reset_pc got %0h want 0", bus.id_pc); end
  endtask

  task automatic test_stream();
    int first = -1;
    int valid_cycles = 0;
    bus.id_ready = 1'b1;
    release_reset();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (first < 0 && bus.id_valid === 1'b1) first = k;
    end
    vectors++;
    if (first != LAT) begin miscompares++; $display("FAIL first_valid_latency got %0d want %0d", first, LAT); end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (bus.id_valid === 1'b1) valid_cycles++;
    end
    vectors++;
    if (valid_cycles != 16) begin miscompares++; $display("FAIL no_bubbles got %0d want 16", valid_cycles); end
  endtask

  task automatic test_stall();
    tick();
    bus.id_ready = 1'b0;
    repeat (10) @(negedge clk);
    vectors += 4;
    if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req got %0b want 0", bus.imem_req); end
    if (bus.id_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid got %0b want 1", bus.id_valid); end
    if (req_cnt - acc_cnt != DEPTH) begin miscompares++; $display("FAIL stall_held got %0d want %0d", req_cnt - acc_cnt, DEPTH); end
    if (bus.id_pc !== exp_q[0].pc) begin miscompares++; $display("FAIL stall_head got %0h want %0h", bus.id_pc, exp_q[0].pc); end
    tick();
    bus.id_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL release_req_same got %0b want 0", bus.imem_req); end
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL release_req_next got %0b want 1", bus.imem_req); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_redirect();
    logic [63:0] want_pc;
    tick();
    reset = 1'b1;
    bus.id_ready = 1'b0;
    release_reset();
    repeat (4) tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h100;
    bus.id_ready    = 1'b1;
    expect_stream(64'h100);
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL redir_req got %0b want 0", bus.imem_req); end
    tick();
    bus.redirect = 1'b0;
    @(negedge clk);
    vectors += 3;
    if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL redir_r1_req got %0b want 1", bus.imem_req); end
    if (bus.imem_addr !== 64'h100) begin miscompares++; $display("FAIL redir_r1_addr got %0h want 100", bus.imem_addr); end
    if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL redir_r1_valid got %0b want 0", bus.id_valid); end
    @(negedge clk);
    vectors++;
    if (bus.id_valid !== (LAT == 1)) begin miscompares++; $display("FAIL redir_r2_valid got %0b want %0b", bus.id_valid, LAT == 1); end
    @(negedge clk);
    want_pc = (LAT == 1) ? 64'h104 : 64'h100;
    vectors += 2;
    if (bus.id_valid !== 1'b1) begin miscompares++; $display("FAIL redir_r3_valid got %0b want 1", bus.id_valid); end
    if (bus.id_pc !== want_pc) begin miscompares++; $display("FAIL redir_r3_pc got %0h want %0h", bus.id_pc, want_pc); end
    repeat (6) @(negedge clk);
  endtask

  task automatic test_redirect_unaligned();
    int a0;
    tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h103;
    expect_stream(64'h100);
    tick();
    bus.redirect = 1'b0;
    a0 = acc_cnt;
    @(negedge clk);
    vectors += 2;
    if (bus.imem_addr !== 64'h100) begin miscompares++; $display("FAIL unaligned_addr got %0h want 100", bus.imem_addr); end
    if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL unaligned_req got %0b want 1", bus.imem_req); end
    repeat (8) tick();
    vectors++;
    if (acc_cnt - a0 < 5) begin miscompares++; $display("FAIL unaligned_progress got %0d want >=5", acc_cnt - a0); end
  endtask

  task automatic test_redirect_full();
    int a0;
    tick();
    bus.id_ready = 1'b0;
    repeat (10) tick();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 64'h200;
    bus.id_ready    = 1'b1;
    expect_stream(64'h200);
    a0 = acc_cnt;
    tick();
    bus.redirect = 1'b0;
    vectors++;
    if (acc_cnt != a0) begin miscompares++; $display("FAIL full_redir_pop got %0d want %0d", acc_cnt, a0); end
    @(negedge clk);
    vectors++;
    if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL full_redir_empty got %0b want 0", bus.id_valid); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    tick();
    bus.id_ready = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    vectors += 4;
    if (bus.imem_req !== 1'b0) begin miscompares++; $display("FAIL mid_reset_req got %0b want 0", bus.imem_req); end
    if (bus.imem_addr !== RESET_PC) begin miscompares++; $display("FAIL mid_reset_addr got %0h want %0h", bus.imem_addr, RESET_PC); end
    if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset_valid got %0b want 0", bus.id_valid); end
    if (bus.id_pc !== 64'h0) begin miscompares++; $display("FAIL mid_reset_pc got %0h want 0", bus.id_pc); end
    bus.id_ready = 1'b1;
    release_reset();
    @(negedge clk);
    vectors += 3;
    if (bus.id_valid !== 1'b0) begin miscompares++; $display("FAIL after_reset_valid got %0b want 0", bus.id_valid); end
    if (bus.imem_addr !== RESET_PC) begin miscompares++; $display("FAIL after_reset_addr got %0h want %0h", bus.imem_addr, RESET_PC); end
    if (bus.imem_req !== 1'b1) begin miscompares++; $display("FAIL after_reset_req got %0b want 1", bus.imem_req); end
    repeat (10) @(negedge clk);
    vectors++;
    if (acc_cnt < 6) begin miscompares++; $display("FAIL after_reset_progress got %0d want >=6", acc_cnt); end
  endtask

  initial begin
    reset           = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.id_ready    = 1'b1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_unaligned();
    test_redirect_full();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
